// File: rtl/raster_scan_ctrl_pkg.sv
// Shared types and constants for the KxK spatial-filter raster controller.
package filter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

  localparam int K_DEF  = 3;
  localparam int MARGIN = K_DEF / 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/raster_scan_ctrl_if.sv
// Pixel-in / window-out stream bundle between the controller and the filter datapath.
interface raster_scan_ctrl_if #(parameter int CW = 8, parameter int RW = 8) ();
  logic          in_valid;
  logic          in_ready;
  logic          out_ready;
  logic          shift_en;
  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic          win_valid;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [3:0]    border;

  modport master (output in_valid, out_ready,
                  input  in_ready, shift_en, in_col, in_row, win_valid, out_col, out_row, border);
  modport slave  (input  in_valid, out_ready,
                  output in_ready, shift_en, in_col, in_row, win_valid, out_col, out_row, border);
endinterface

// File: rtl/raster_scan_ctrl_counter.sv
// Modulo counter with clear; max_tick flags the terminal count so instances can be chained.
module counter #(
  parameter int CNT_MOD = 4,
  parameter int W       = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         max_tick
);
  assign max_tick = (cnt == W'(CNT_MOD - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)  cnt <= '0;
    else if (en)       cnt <= max_tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/raster_scan_ctrl.sv
// Frame sequencer for the KxK filter: input handshake, priming delay, flush, window tagging.
// Optional BORDER_FLAGS_EN drives edge-proximity flags; otherwise border is 0 and the datapath zero-pads.
module raster_scan_ctrl
  import filter_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int K     = K_DEF,
  parameter int CW    = 8,
  parameter int RW    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic frame_done,
  raster_scan_ctrl_if.slave bus
);
  localparam int M  = K / 2;
  localparam int D  = IMG_W * M + M;
  localparam int DW = (clog2(D + 1) < 1) ? 1 : clog2(D + 1);

  state_t state, nxt;
  logic [DW-1:0] dly;
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic ic_max, ir_max, oc_max, or_max;
  logic acc, primed, clr, last_in, last_out;

  assign bus.in_ready  = (state == ACTIVE) & bus.out_ready;
  assign acc           = bus.in_valid & bus.in_ready;
  assign bus.shift_en  = acc | ((state == FLUSH) & bus.out_ready);
  assign primed        = (dly == DW'(D));
  assign bus.win_valid = bus.shift_en & primed;
  assign clr           = (state == IDLE);
  assign last_in       = acc & ic_max & ir_max;
  assign last_out      = bus.win_valid & oc_max & or_max;

  // Priming delay: counts shifts until the first full window exists, then holds.
  always_ff @(posedge clk) begin
    if (reset || clr)                dly <= '0;
    else if (bus.shift_en && !primed) dly <= dly + 1'b1;
  end

  counter #(.CNT_MOD(IMG_W), .W(CW)) u_in_col (.clk, .reset, .clr, .en(acc),
    .cnt(in_col), .max_tick(ic_max));
  counter #(.CNT_MOD(IMG_H), .W(RW)) u_in_row (.clk, .reset, .clr, .en(acc & ic_max),
    .cnt(in_row), .max_tick(ir_max));
  counter #(.CNT_MOD(IMG_W), .W(CW)) u_out_col (.clk, .reset, .clr, .en(bus.win_valid),
    .cnt(out_col), .max_tick(oc_max));
  counter #(.CNT_MOD(IMG_H), .W(RW)) u_out_row (.clk, .reset, .clr, .en(bus.win_valid & oc_max),
    .cnt(out_row), .max_tick(or_max));

  assign bus.in_col  = in_col;
  assign bus.in_row  = in_row;
  assign bus.out_col = out_col;
  assign bus.out_row = out_row;

`ifdef BORDER_FLAGS_EN
  assign bus.border = {out_row < RW'(M), out_row > RW'(IMG_H - 1 - M),
                       out_col < CW'(M), out_col > CW'(IMG_W - 1 - M)};
`else
  assign bus.border = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start)    nxt = ACTIVE;
      ACTIVE:  if (last_in)  nxt = FLUSH;
      FLUSH:   if (last_out) nxt = DONE;
      DONE:                  nxt = IDLE;
      default:               nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    if (state != IDLE) busy = 1'b1;
    if (state == DONE) frame_done = 1'b1;
  end
endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench for raster_scan_ctrl at 4x3, K=3: cycle model for handshake, queue for window order.
module tb_raster_scan_ctrl;
  localparam int W = 4, H = 3, K = 3, CW = 2, RW = 2;
  localparam int M = K / 2;
  localparam int D = W * M + M;
  localparam int N = W * H;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy, frame_done;
  raster_scan_ctrl_if #(.CW(CW), .RW(RW)) bus ();

  raster_scan_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .CW(CW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // model: 0 idle, 1 active, 2 flush, 3 done
  int m_state = 0, m_ic = 0, m_ir = 0, m_sh = 0, m_win = 0;
  logic [31:0] q[$];

  function automatic logic [3:0] exp_border(input int c, input int r);
`ifdef BORDER_FLAGS_EN
    return {r < M, r > H - 1 - M, c < M, c > W - 1 - M};
`else
    return 4'b0000;
`endif
  endfunction

  always @(negedge clk) begin
    bit e_ir, e_acc, e_sh, e_wv;
    logic [31:0] e;
    e_ir  = (m_state == 1) && bus.out_ready;
    e_acc = e_ir && bus.in_valid;
    e_sh  = e_acc || ((m_state == 2) && bus.out_ready);
    e_wv  = e_sh && (m_sh >= D);
    chk("in_ready", bus.in_ready, e_ir);
    chk("shift_en", bus.shift_en, e_sh);
    chk("win_valid", bus.win_valid, e_wv);
    chk("busy", busy, m_state != 0);
    chk("frame_done", frame_done, m_state == 3);
    if (e_acc) chk("in_coord", {bus.in_col, bus.in_row}, {m_ic[1:0], m_ir[1:0]});
    if (m_state == 0)
      chk("idle_coords", {bus.in_col, bus.in_row, bus.out_col, bus.out_row}, 0);
    if (bus.win_valid) begin
      if (q.size() == 0) chk("win_extra", 1, 0);
      else begin
        e = q.pop_front();
        chk("out_coord", {bus.out_col, bus.out_row}, e[5:2]);
        chk("border", bus.border, e[9:6]);
      end
    end
    m_sh  += int'(e_sh);
    m_win += int'(e_wv);
    if (reset) begin
      m_state = 0; q.delete();
    end else begin
      case (m_state)
        0: if (start) begin
             m_state = 1; m_ic = 0; m_ir = 0; m_sh = 0; m_win = 0;
             for (int r = 0; r < H; r++)
               for (int c = 0; c < W; c++)
                 q.push_back({22'd0, exp_border(c, r), c[1:0], r[1:0], 2'b00});
           end
        1: if (e_acc) begin
             if (m_ic == W - 1) begin
               m_ic = 0;
               if (m_ir == H - 1) begin m_ir = 0; m_state = 2; end
               else m_ir++;
             end else m_ic++;
           end
        2: if (m_win == N) m_state = 3;
        default: begin
          chk("frame_shifts", m_sh, N + D);
          chk("frame_windows", m_win, N);
          chk("queue_empty", q.size(), 0);
          m_state = 0;
        end
      endcase
    end
  end

  // mode: 0 plain, 1 out_ready stalls, 2 in_valid toggling, 3 mid-frame reset, 4 stray starts
  task automatic run_frame(input int mode);
    int cyc = 0, a_cyc = 0, f_cyc = 0;
    start = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      start = 1'b0; reset = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      cyc++;
      if (m_state == 0) return;
      if (cyc > 200) begin chk("frame_timeout", 1, 0); return; end
      if (m_state == 1) a_cyc++;
      if (m_state == 2) f_cyc++;
      case (mode)
        1: bus.out_ready = !((m_state == 1 && a_cyc >= 3 && a_cyc <= 5) ||
                             (m_state == 2 && f_cyc >= 1 && f_cyc <= 3));
        2: bus.in_valid = cyc[0];
        3: if (m_state == 1 && m_ic == 2 && m_ir == 1) reset = 1'b1;
        4: start = (m_state == 1 && a_cyc == 4) || (m_state == 2 && f_cyc == 2);
        default: ;
      endcase
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    repeat (3) @(posedge clk);
    #1;
    run_frame(0);
    run_frame(4);
    run_frame(0);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
